dht_sensor_reader: RTL
======================

// Module: dht_sensor_reader
// PURPOSE
// Single-wire DHT-family sensor controller, successor to the fixed-timing DHT11 reader. Pulse-width bit decoding,
// selectable DHT11/DHT22 frame format, checksum verification, per-phase timeouts, on-demand or periodic sampling.
// Sits between the sensor pad (open-drain inout) and the SoC register/bus slave that consumes readings.
// PARAMETERS
// CLK_FREQ_HZ      50_000_000  system clock; sets the 1 us tick prescaler (CLK_FREQ_HZ/1_000_000 cycles)
// START_LOW_US     18000       host start-pulse low time, DHT11 mode (DHT22 mode uses 1100 fixed)
// BIT_THRESH_US    50          data-high pulse longer than this decodes as 1, else 0
// TIMEOUT_US       200         max duration of any single line phase before abort
// MIN_INTERVAL_MS  2000        holdoff from end of one transaction to the start of the next
// SYNC_STAGES      2           input synchroniser depth on data pin
// PORTS
// clk          in    1   system clock
// reset        in    1   synchronous, active-high
// data         inout 1   sensor line; driven only 0 or Z (open drain, external pull-up)
// start        in    1   one-cycle request for a single read
// auto_en      in    1   1 = self-trigger every MIN_INTERVAL_MS
// mode         in    1   0 = DHT11, 1 = DHT22; sampled at transaction start
// humidity     out   16  relative humidity, unsigned, 0.1 %RH units
// temperature  out   16  temperature, two's complement, 0.1 degC units
// valid        out   1   one-cycle pulse when humidity/temperature update
// busy         out   1   high from accepted start to end of holdoff
// error        out   1   one-cycle pulse on failed transaction
// err_code     out   2   0 none, 1 no response, 2 bit timeout, 3 checksum; held until next transaction
// BEHAVIOUR
// Reset: line released (Z), all outputs 0, FSM IDLE, holdoff counter cleared. Reset mid-transaction aborts at once, no error pulse.
// Timing: 1 us tick from prescaler; all phase counters count ticks, saturating at TIMEOUT_US+1.
// Line sampled only via SYNC_STAGES flop synchroniser; edges detected on the synchronised value.
// FSM:
//  IDLE      -> START_LOW when (start | auto_en) & !holdoff; latch mode; busy=1; err_code=0
//  START_LOW drive 0 for START_LOW_US (or 1100 us) -> RELEASE
//  RELEASE   Z; wait falling edge -> RESP_LOW; TIMEOUT_US elapsed -> FAIL(1)
//  RESP_LOW  wait rising edge -> RESP_HIGH; timeout -> FAIL(1)
//  RESP_HIGH wait falling edge -> BIT_LOW, bit_cnt=0; timeout -> FAIL(1)
//  BIT_LOW   wait rising edge -> BIT_HIGH, clear width; timeout -> FAIL(2)
//  BIT_HIGH  on falling edge shift (width>BIT_THRESH_US) into 40-bit buffer MSB-first; bit_cnt==39 -> CHECK else BIT_LOW;
//            timeout -> FAIL(2). Last bit's falling edge is the sensor's trailing low.
//  CHECK     (b0+b1+b2+b3) mod 256 == b4 -> DONE else FAIL(3)
//  DONE      load outputs, valid pulse -> HOLD
//  FAIL      err_code set, error pulse, outputs keep previous values -> HOLD
//  HOLD      Z; count MIN_INTERVAL_MS; start ignored (dropped, not queued); then IDLE, busy=0
// Decode (b0..b4 = frame bytes, b0 first):
//  DHT22: humidity={b0,b1}; temperature = b2[7] ? -{b2[6:0],b3} : {b2[6:0],b3}
//  DHT11: humidity=b0*10+b1[3:0]; temperature = b3[7] ? -(b2*10+b3[3:0]) : (b2*10+b3[3:0])
// Arithmetic in 16 bits; no overflow possible for 8-bit inputs. valid and error are never high together.
// start while busy: ignored. start and auto_en together: single transaction.
// STRUCTURE
// Shared package dht_pkg: state encoding, err_code constants (ERR_NONE/NORESP/BITTO/CKSUM), DHT22 start-low 1100.
// Sub-module dht_us_tick: prescaler producing 1-cycle tick every CLK_FREQ_HZ/1e6 clocks, sync reset.
// Sensor behavioural model (bench only) drives pulse widths: 80/80 us response, 50 us low, 26 us (0) / 70 us (1) high.
// TESTING
// DHT22 frame 02 8C 01 5F EE -> humidity=652, temperature=351, valid 1 cycle, err_code=0
// DHT22 frame 02 8C 80 65 73 -> temperature=0xFF9B (-101), valid pulse
// DHT11 frame 37 00 18 00 4F -> humidity=550, temperature=240; start low measured 18000 us +/-1 tick
// Frame 02 8C 01 5F EF -> error pulse, err_code=3, humidity/temperature unchanged, no valid
// No sensor (line stays high after release) -> err_code=1 after 200 us; sensor stops mid-bit 17 -> err_code=2
// start during HOLD ignored; auto_en=1 -> transactions spaced 2000 ms; reset during BIT_HIGH -> line Z next cycle, outputs 0

Source files
------------

// File: rtl/dht_pkg.sv
// Shared definitions for the DHT sensor reader: FSM encoding, error codes and the
// DHT11 integer/tenths decode helper.
package dht_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StStartLow,
      StRelease,
      StRespLow,
      StRespHigh,
      StBitLow,
      StBitHigh,
      StCheck,
      StDone,
      StFail,
      StHold
   } dht_state_e;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_NORESP = 2'd1;
   localparam logic [1:0] ERR_BITTO  = 2'd2;
   localparam logic [1:0] ERR_CKSUM  = 2'd3;

   localparam int unsigned DHT22_START_LOW_US = 1100;

   // DHT11 sends the integer part and the tenths digit in separate bytes.
   function automatic logic [15:0] dht11_tenths(input logic [7:0] int_part,
                                                input logic [3:0] frac);
      return 16'(int_part) * 16'd10 + 16'(frac);
   endfunction

endpackage

// File: rtl/dht_us_tick.sv
// Prescaler emitting a one-cycle pulse every DIV clocks (1 us time base).
module dht_us_tick #(
   parameter int unsigned DIV = 50
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (count == CW'(DIV - 1)) begin
         count <= '0;
         tick  <= 1'b1;
      end else begin
         count <= count + CW'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/dht_sensor_reader.sv
// Single-wire DHT11/DHT22 reader: start pulse, pulse-width bit decode, checksum,
// per-phase timeouts and a post-transaction holdoff.
module dht_sensor_reader
   import dht_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
   parameter int unsigned START_LOW_US    = 18000,
   parameter int unsigned BIT_THRESH_US   = 50,
   parameter int unsigned TIMEOUT_US      = 200,
   parameter int unsigned MIN_INTERVAL_MS = 2000,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic        clk,
   input  logic        reset,
   inout  wire         data,
   input  logic        start,
   input  logic        auto_en,
   input  logic        mode,
   output logic [15:0] humidity,
   output logic [15:0] temperature,
   output logic        valid,
   output logic        busy,
   output logic        error,
   output logic [1:0]  err_code
);

   localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1_000_000;
   localparam int unsigned HOLD_US  = MIN_INTERVAL_MS * 1000;
   localparam int unsigned MAX_A    = (START_LOW_US > DHT22_START_LOW_US) ?
                                      START_LOW_US : DHT22_START_LOW_US;
   localparam int unsigned MAX_B    = (HOLD_US > TIMEOUT_US + 1) ? HOLD_US : TIMEOUT_US + 1;
   localparam int unsigned CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

   logic                   tick;
   dht_state_e             state;
   logic                   drive_low;
   logic [SYNC_STAGES-1:0] sync;
   logic                   line_prev;
   logic [CNT_W-1:0]       cnt;
   logic [5:0]             bit_cnt;
   logic [39:0]            frame;
   logic                   mode_lat;
   logic [1:0]             fail_code;

   logic             line, rise, fall, wait_state, timed_out, cksum_ok;
   logic [7:0]       b0, b1, b2, b3, b4, sum;
   logic [15:0]      hum_dec, temp_dec, mag;
   logic [CNT_W-1:0] start_len;

   dht_us_tick #(
      .DIV(TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   assign data = drive_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync      <= '1;
         line_prev <= 1'b1;
      end else begin
         sync      <= (sync << 1) | SYNC_STAGES'(data);
         line_prev <= line;
      end
   end

   always_comb begin
      line       = sync[SYNC_STAGES-1];
      rise       = line & ~line_prev;
      fall       = ~line & line_prev;
      wait_state = state inside {StRelease, StRespLow, StRespHigh, StBitLow, StBitHigh};
      timed_out  = cnt > CNT_W'(TIMEOUT_US);
      start_len  = mode_lat ? CNT_W'(DHT22_START_LOW_US) : CNT_W'(START_LOW_US);
      {b0, b1, b2, b3, b4} = frame;
      sum        = b0 + b1 + b2 + b3;
      cksum_ok   = (sum == b4);
      if (mode_lat) begin
         hum_dec  = {b0, b1};
         mag      = {1'b0, b2[6:0], b3};
         temp_dec = b2[7] ? 16'd0 - mag : mag;
      end else begin
         hum_dec  = dht11_tenths(b0, b1[3:0]);
         mag      = dht11_tenths(b2, b3[3:0]);
         temp_dec = b3[7] ? 16'd0 - mag : mag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         drive_low   <= 1'b0;
         cnt         <= '0;
         bit_cnt     <= '0;
         frame       <= '0;
         mode_lat    <= 1'b0;
         fail_code   <= ERR_NONE;
         humidity    <= '0;
         temperature <= '0;
         valid       <= 1'b0;
         busy        <= 1'b0;
         error       <= 1'b0;
         err_code    <= ERR_NONE;
      end else begin
         valid <= 1'b0;
         error <= 1'b0;
         // Phase timer; edge-wait phases saturate just past the timeout.
         if (tick && !(wait_state && timed_out)) cnt <= cnt + CNT_W'(1);
         unique case (state)
            StIdle: begin
               if (start || auto_en) begin
                  mode_lat  <= mode;
                  busy      <= 1'b1;
                  err_code  <= ERR_NONE;
                  drive_low <= 1'b1;
                  cnt       <= '0;
                  state     <= StStartLow;
               end
            end
            StStartLow: begin
               if (tick && cnt == start_len - CNT_W'(1)) begin
                  drive_low <= 1'b0;
                  cnt       <= '0;
                  state     <= StRelease;
               end
            end
            StRelease: begin
               if (fall) begin
                  cnt   <= '0;
                  state <= StRespLow;
               end else if (timed_out) begin
                  fail_code <= ERR_NORESP;
                  state     <= StFail;
               end
            end
            StRespLow: begin
               if (rise) begin
                  cnt   <= '0;
                  state <= StRespHigh;
               end else if (timed_out) begin
                  fail_code <= ERR_NORESP;
                  state     <= StFail;
               end
            end
            StRespHigh: begin
               if (fall) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= StBitLow;
               end else if (timed_out) begin
                  fail_code <= ERR_NORESP;
                  state     <= StFail;
               end
            end
            StBitLow: begin
               if (rise) begin
                  cnt   <= '0;
                  state <= StBitHigh;
               end else if (timed_out) begin
                  fail_code <= ERR_BITTO;
                  state     <= StFail;
               end
            end
            StBitHigh: begin
               if (fall) begin
                  frame <= {frame[38:0], cnt > CNT_W'(BIT_THRESH_US)};
                  cnt   <= '0;
                  if (bit_cnt == 6'd39) begin
                     state <= StCheck;
                  end else begin
                     bit_cnt <= bit_cnt + 6'd1;
                     state   <= StBitLow;
                  end
               end else if (timed_out) begin
                  fail_code <= ERR_BITTO;
                  state     <= StFail;
               end
            end
            StCheck: begin
               if (cksum_ok) begin
                  state <= StDone;
               end else begin
                  fail_code <= ERR_CKSUM;
                  state     <= StFail;
               end
            end
            StDone: begin
               humidity    <= hum_dec;
               temperature <= temp_dec;
               valid       <= 1'b1;
               cnt         <= '0;
               state       <= StHold;
            end
            StFail: begin
               err_code <= fail_code;
               error    <= 1'b1;
               cnt      <= '0;
               state    <= StHold;
            end
            StHold: begin
               if (tick && cnt == CNT_W'(HOLD_US - 1)) begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
